// File: rtl/nmea_pkg.sv
// nmea_pkg: shared constants, state encoding and character-class helpers
// for the NMEA ZDA sentence parser.
package nmea_pkg;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_DOT    = 8'h2E;
  localparam logic [7:0] CH_MINUS  = 8'h2D;
  localparam logic [7:0] CH_0      = 8'h30;
  localparam logic [7:0] CH_9      = 8'h39;
  localparam logic [7:0] CH_A      = 8'h41;
  localparam logic [7:0] CH_F      = 8'h46;
  localparam logic [7:0] CH_Z      = 8'h5A;
  localparam logic [7:0] CH_G      = 8'h47;
  localparam logic [7:0] CH_P      = 8'h50;
  localparam logic [7:0] CH_D      = 8'h44;

  typedef enum logic [3:0] {
    IDLE, HDR, F_TIME, F_DAY, F_MON, F_YEAR, F_SKIP, CKS_HI, CKS_LO
  } state_t;

  // Field index doubles as the digit_valid bit position.
  localparam int unsigned FLD_HH   = 0;
  localparam int unsigned FLD_MM   = 1;
  localparam int unsigned FLD_SS   = 2;
  localparam int unsigned FLD_DD   = 3;
  localparam int unsigned FLD_MON  = 4;
  localparam int unsigned FLD_YYYY = 5;

  localparam int unsigned NDIG_TIME = 6;
  localparam int unsigned NDIG_DAY  = 2;
  localparam int unsigned NDIG_MON  = 2;
  localparam int unsigned NDIG_YEAR = 4;
  localparam int unsigned HDR_LEN   = 5;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= CH_A) && (c <= CH_Z);
  endfunction

  // Uppercase hex only; lowercase is deliberately rejected.
  function automatic logic is_hex(input logic [7:0] c);
    return is_digit(c) || ((c >= CH_A) && (c <= CH_F));
  endfunction

  function automatic logic [3:0] hex_nib(input logic [7:0] c);
    return is_digit(c) ? c[3:0] : c[3:0] + 4'd9;
  endfunction

endpackage

// File: rtl/nmea_checksum.sv
// nmea_checksum: running XOR of sentence bytes plus checksum-char decode.
//   clk, rst_n   : clock, async active-low reset
//   clr_i        : clear the running XOR (start of sentence)
//   en_i         : XOR data_i into the accumulator
//   data_i       : current received byte
//   load_hi_i    : latch data_i as the high checksum nibble
//   hex_ok_o     : data_i is an uppercase hex character
//   match_o      : {latched high nibble, data_i nibble} equals the XOR
module nmea_checksum
  import nmea_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  input  logic       load_hi_i,
  output logic       hex_ok_o,
  output logic       match_o
);

  logic [7:0] acc_q, acc_d;
  logic [3:0] hi_q, hi_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q ^ data_i;
    hi_d = load_hi_i ? hex_nib(data_i) : hi_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      hi_q  <= '0;
    end else begin
      acc_q <= acc_d;
      hi_q  <= hi_d;
    end
  end

  assign hex_ok_o = is_hex(data_i);
  assign match_o  = ({hi_q, hex_nib(data_i)} == acc_q);

endmodule

// File: rtl/nmea_zda_parser.sv
// nmea_zda_parser: finds $xxZDA sentences in a UART byte stream, steers the
// time/date digits to six ascii2bin lanes and reports one frame_ok or
// frame_err pulse per ZDA sentence.
//   clk, rst_n  : clock, async active-low reset
//   uart_data   : received byte, qualified by uart_valid
//   uart_valid  : one-cycle byte strobe
//   ascii_out   : registered copy of the last routed digit
//   digit_valid : one-hot lane strobe (hh, mm, ss, dd, MM, yyyy)
//   frame_ok    : sentence well formed with matching checksum
//   frame_err   : ZDA sentence malformed, aborted or checksum mismatch
//   busy        : a sentence is being parsed
module nmea_zda_parser
  import nmea_pkg::*;
#(
  parameter int unsigned TALKER_CHECK = 1,
  parameter int unsigned MAX_LEN      = 82,
  parameter int unsigned FRAC_MAX     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] uart_data,
  input  logic       uart_valid,
  output logic [7:0] ascii_out,
  output logic [5:0] digit_valid,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW = $clog2(MAX_LEN + 2);
  localparam int unsigned DW = $clog2(NDIG_TIME + FRAC_MAX + 1);

  state_t          state_q, state_d;
  logic [2:0]      hcnt_q, hcnt_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            frac_q, frac_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      ascii_q, ascii_d;
  logic [5:0]      dv_q, dv_d;
  logic            ok_q, ok_d;
  logic            err_q, err_d;

  logic            is_dig, hdr_ok, fail, route;
  logic [2:0]      fld;
  logic [CW-1:0]   cnt_inc;
  logic [DW-1:0]   fld_len;
  logic [2:0]      fld_sel;
  state_t          fld_next;
  logic            ck_clr, ck_en, ck_hi, hex_ok, ck_match;

  nmea_checksum u_cks (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (ck_clr),
    .en_i      (ck_en),
    .data_i    (uart_data),
    .load_hi_i (ck_hi),
    .hex_ok_o  (hex_ok),
    .match_o   (ck_match)
  );

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    dcnt_d  = dcnt_q;
    frac_d  = frac_q;
    cnt_d   = cnt_q;
    ascii_d = ascii_q;
    dv_d    = '0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    ck_clr  = 1'b0;
    ck_en   = 1'b0;
    ck_hi   = 1'b0;
    fail    = 1'b0;
    route   = 1'b0;
    fld     = '0;

    is_dig  = is_digit(uart_data);
    // Saturates at MAX_LEN+1 so an over-long sentence can never wrap back.
    cnt_inc = (cnt_q > CW'(MAX_LEN)) ? cnt_q : cnt_q + CW'(1);

    case (hcnt_q)
      3'd0:    hdr_ok = (TALKER_CHECK != 0) ? (uart_data == CH_G) : is_upper(uart_data);
      3'd1:    hdr_ok = (TALKER_CHECK != 0) ? (uart_data == CH_P) : is_upper(uart_data);
      3'd2:    hdr_ok = (uart_data == CH_Z);
      3'd3:    hdr_ok = (uart_data == CH_D);
      3'd4:    hdr_ok = (uart_data == CH_A);
      default: hdr_ok = 1'b0;
    endcase

    case (state_q)
      F_DAY: begin
        fld_len = DW'(NDIG_DAY);  fld_sel = 3'(FLD_DD);   fld_next = F_MON;
      end
      F_MON: begin
        fld_len = DW'(NDIG_MON);  fld_sel = 3'(FLD_MON);  fld_next = F_YEAR;
      end
      default: begin
        fld_len = DW'(NDIG_YEAR); fld_sel = 3'(FLD_YYYY); fld_next = F_SKIP;
      end
    endcase

    if (uart_valid) begin
      if (uart_data == CH_DOLLAR) begin
        // Restart; only a sentence already identified as ZDA reports an error.
        if (state_q != IDLE && (state_q != HDR || hcnt_q == 3'(HDR_LEN)))
          err_d = 1'b1;
        state_d = HDR;
        hcnt_d  = '0;
        dcnt_d  = '0;
        frac_d  = 1'b0;
        cnt_d   = CW'(1);
        ck_clr  = 1'b1;
      end else if (state_q != IDLE) begin
        cnt_d = cnt_inc;
        ck_en = !(state_q == F_SKIP && uart_data == CH_STAR) &&
                !(state_q inside {CKS_HI, CKS_LO});
        unique case (state_q)
          HDR: begin
            if (hcnt_q < 3'(HDR_LEN)) begin
              if (hdr_ok) hcnt_d = hcnt_q + 3'd1;
              else        state_d = IDLE;
            end else if (uart_data == CH_COMMA) begin
              state_d = F_TIME;
              dcnt_d  = '0;
            end else begin
              fail = 1'b1;
            end
          end
          F_TIME: begin
            if (!frac_q) begin
              if (dcnt_q < DW'(NDIG_TIME)) begin
                if (is_dig) begin
                  route  = 1'b1;
                  fld    = 3'(FLD_HH) + 3'(dcnt_q >> 1);
                  dcnt_d = dcnt_q + DW'(1);
                end else begin
                  fail = 1'b1;
                end
              end else if (uart_data == CH_COMMA) begin
                state_d = F_DAY;
                dcnt_d  = '0;
              end else if (uart_data == CH_DOT) begin
                frac_d = 1'b1;
              end else begin
                fail = 1'b1;
              end
            end else begin
              // Fraction digits are counted on top of the 6 time digits.
              if (is_dig && dcnt_q < DW'(NDIG_TIME + FRAC_MAX)) begin
                dcnt_d = dcnt_q + DW'(1);
              end else if (uart_data == CH_COMMA) begin
                state_d = F_DAY;
                dcnt_d  = '0;
                frac_d  = 1'b0;
              end else begin
                fail = 1'b1;
              end
            end
          end
          F_DAY, F_MON, F_YEAR: begin
            if (dcnt_q < fld_len) begin
              if (is_dig) begin
                route  = 1'b1;
                fld    = fld_sel;
                dcnt_d = dcnt_q + DW'(1);
              end else begin
                fail = 1'b1;
              end
            end else if (uart_data == CH_COMMA) begin
              state_d = fld_next;
              dcnt_d  = '0;
            end else begin
              fail = 1'b1;
            end
          end
          F_SKIP: begin
            if (uart_data == CH_STAR)
              state_d = CKS_HI;
            else if (!(is_dig || uart_data == CH_MINUS || uart_data == CH_COMMA))
              fail = 1'b1;
          end
          CKS_HI: begin
            if (hex_ok) begin
              ck_hi   = 1'b1;
              state_d = CKS_LO;
            end else begin
              fail = 1'b1;
            end
          end
          CKS_LO: begin
            state_d = IDLE;
            if (hex_ok && ck_match) ok_d  = 1'b1;
            else                    err_d = 1'b1;
          end
          default: ;
        endcase

        if (state_q != HDR && cnt_inc > CW'(MAX_LEN))
          fail = 1'b1;

        if (fail) begin
          state_d = IDLE;
          err_d   = 1'b1;
          ok_d    = 1'b0;
          route   = 1'b0;
        end
      end
    end

    if (route) begin
      dv_d    = 6'(1) << fld;
      ascii_d = uart_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      dcnt_q  <= '0;
      frac_q  <= 1'b0;
      cnt_q   <= '0;
      ascii_q <= '0;
      dv_q    <= '0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      dcnt_q  <= dcnt_d;
      frac_q  <= frac_d;
      cnt_q   <= cnt_d;
      ascii_q <= ascii_d;
      dv_q    <= dv_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
    end
  end

  assign ascii_out   = ascii_q;
  assign digit_valid = dv_q;
  assign frame_ok    = ok_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_nmea_zda_parser.sv
// Directed bench for nmea_zda_parser: one instance with the GP talker check,
// one accepting any talker, both fed the same byte stream.
module tb_nmea_zda_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] uart_data = '0;
  logic       uart_valid = 1'b0;

  logic [7:0] a_ascii, b_ascii;
  logic [5:0] a_dv, b_dv;
  logic       a_ok, a_err, a_busy, b_ok, b_err, b_busy;

  nmea_zda_parser #(.TALKER_CHECK(1), .MAX_LEN(82), .FRAC_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .uart_data(uart_data), .uart_valid(uart_valid),
    .ascii_out(a_ascii), .digit_valid(a_dv), .frame_ok(a_ok),
    .frame_err(a_err), .busy(a_busy)
  );

  nmea_zda_parser #(.TALKER_CHECK(0), .MAX_LEN(82), .FRAC_MAX(3)) dut0 (
    .clk(clk), .rst_n(rst_n), .uart_data(uart_data), .uart_valid(uart_valid),
    .ascii_out(b_ascii), .digit_valid(b_dv), .frame_ok(b_ok),
    .frame_err(b_err), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    fails = 0;
  string seq, fld;
  int    ok_cnt, err_cnt, ok_idx, err_idx, bidx, stray;
  int    dv_cnt0, ok0_cnt, err0_cnt;
  int    busy_at_err;

  localparam string S1 = "$GPZDA,201530.00,04,07,2002,00,00*60\r\n";

  function automatic string lane(input logic [5:0] v);
    case (v)
      6'd1:    return "0";
      6'd2:    return "1";
      6'd4:    return "2";
      6'd8:    return "3";
      6'd16:   return "4";
      6'd32:   return "5";
      default: return "X";
    endcase
  endfunction

  task automatic clear_stats();
    seq = ""; fld = "";
    ok_cnt = 0; err_cnt = 0; ok_idx = 0; err_idx = 0; bidx = 0; stray = 0;
    dv_cnt0 = 0; ok0_cnt = 0; err0_cnt = 0; busy_at_err = -1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    uart_data  = b;
    uart_valid = 1'b1;
    @(posedge clk);
    #1;
    bidx++;
    if (a_dv != '0) begin
      seq = $sformatf("%s%c", seq, a_ascii);
      fld = $sformatf("%s%s", fld, lane(a_dv));
    end
    if (a_ok) begin ok_cnt++; ok_idx = bidx; end
    if (a_err) begin err_cnt++; err_idx = bidx; busy_at_err = int'(a_busy); end
    if (b_dv != '0) dv_cnt0++;
    if (b_ok) ok0_cnt++;
    if (b_err) err0_cnt++;
    @(negedge clk);
    uart_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (a_dv != '0 || a_ok || a_err || b_dv != '0 || b_ok || b_err) stray++;
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_str(input string tag, input string act, input string exp);
    tests++;
    assert (act == exp) else begin
      fails++;
      $error("FAIL %s: observed '%s' expected '%s'", tag, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s;
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_outputs", int'({a_ascii, a_dv, a_ok, a_err, a_busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: reference sentence
    clear_stats();
    send_str(S1);
    check_str("t1_digits", seq, "20153004072002");
    check_str("t1_lanes", fld, "00112233445555");
    check_int("t1_ok_cnt", ok_cnt, 1);
    check_int("t1_ok_idx", ok_idx, 36);
    check_int("t1_err_cnt", err_cnt, 0);
    check_int("t1_stray", stray, 0);
    check_int("t1_last_ascii", int'(a_ascii), 8'h32);

    // 2: checksum mismatch
    clear_stats();
    send_str("$GPZDA,201530.00,04,07,2002,00,00*61\r\n");
    check_str("t2_digits", seq, "20153004072002");
    check_int("t2_err_cnt", err_cnt, 1);
    check_int("t2_err_idx", err_idx, 36);
    check_int("t2_ok_cnt", ok_cnt, 0);

    // 3: non-ZDA sentence is silently ignored
    clear_stats();
    send_str("$GPGGA,123519,4807.038,N*47\r\n");
    check_int("t3_gga_strobes", seq.len(), 0);
    check_int("t3_gga_pulses", ok_cnt + err_cnt, 0);
    check_int("t3_gga_busy", int'(a_busy), 0);
    send_str(S1);
    check_str("t3_zda_digits", seq, "20153004072002");
    check_int("t3_zda_ok", ok_cnt, 1);
    check_int("t3_zda_err", err_cnt, 0);

    // 4: short time field
    clear_stats();
    send_str("$GPZDA,2015,04,07,2002,00,00*60\r\n");
    check_str("t4_digits", seq, "2015");
    check_str("t4_lanes", fld, "0011");
    check_int("t4_err_cnt", err_cnt, 1);
    check_int("t4_err_idx", err_idx, 12);
    check_int("t4_busy_at_err", busy_at_err, 0);
    check_int("t4_ok_cnt", ok_cnt, 0);
    clear_stats();
    send_str(S1);
    check_int("t4_recover_ok", ok_cnt, 1);
    check_int("t4_recover_err", err_cnt, 0);

    // 5: reset in the middle of the year field
    clear_stats();
    send_str("$GPZDA,201530.00,04,07,20");
    check_int("t5_busy_before", int'(a_busy), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_int("t5_outputs_in_reset", int'({a_ascii, a_dv, a_ok, a_err, a_busy}), 0);
    repeat (2) @(posedge clk);
    #1;
    check_int("t5_outputs_held", int'({a_ascii, a_dv, a_ok, a_err, a_busy}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    send_str(S1);
    check_int("t5_ok", ok_cnt, 1);
    check_int("t5_err", err_cnt, 0);

    // 6: talker check on/off
    clear_stats();
    send_str("$GNZDA,201530.00,04,07,2002,00,00*7E\r\n");
    check_int("t6_any_talker_ok", ok0_cnt, 1);
    check_int("t6_any_talker_err", err0_cnt, 0);
    check_int("t6_any_talker_strobes", dv_cnt0, 14);
    check_int("t6_gp_only_silent", ok_cnt + err_cnt + seq.len(), 0);

    // 6b: over-long sentence with no '*'
    clear_stats();
    s = "$GPZDA,201530.00,04,07,2002,";
    while (s.len() < 90) s = {s, "0"};
    send_str(s);
    check_int("t6_long_err_cnt", err_cnt, 1);
    check_int("t6_long_err_idx", err_idx, 83);
    check_int("t6_long_ok", ok_cnt, 0);
    check_int("t6_long_busy", int'(a_busy), 0);

    // Time field without fraction; lowercase checksum rejected
    clear_stats();
    send_str("$GPZDA,201530,04,07,2002,00,00*4E\r\n");
    check_int("nofrac_ok", ok_cnt, 1);
    check_int("nofrac_err", err_cnt, 0);
    clear_stats();
    send_str("$GPZDA,201530,04,07,2002,00,00*4e\r\n");
    check_int("lower_hex_err", err_cnt, 1);
    check_int("lower_hex_ok", ok_cnt, 0);

    // '$' restart after ZDA header matched
    clear_stats();
    send_str({"$GPZDA,2015", S1});
    check_int("restart_err_idx", err_idx, 12);
    check_int("restart_err_cnt", err_cnt, 1);
    check_int("restart_ok_cnt", ok_cnt, 1);
    check_int("restart_ok_idx", ok_idx, 47);
    check_int("restart_stray", stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nmea_zda_parser.md
Name: nmea_zda_parser

Overview:
Byte-level NMEA 0183 sentence parser that sits between the UART receiver and the ascii2bin converters. It finds "$xxZDA" sentences and splits them into hour, minute, second, day, month and year digit streams, each steered to its own downstream ascii2bin instance. It checks digit counts and the XOR checksum, then issues one frame_ok or frame_err pulse per sentence. Downstream latches decoded values only on frame_ok.

Parameters:
TALKER_CHECK, 1, 1: talker ID must be "GP"; 0: any two uppercase letters A-Z accepted (GN, GL, ...).
MAX_LEN, 82, maximum characters from '$' to the second checksum char inclusive; exceeding this is a frame error.
FRAC_MAX, 3, maximum fractional-second digits accepted after '.' in the time field.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_data  in  8  received byte
uart_valid  in  1  one-cycle strobe, byte valid; at least 2 idle cycles between strobes
ascii_out  out  8  registered copy of the current digit character
digit_valid  out  6  one-hot steering strobe; bit 0 hh, 1 mm, 2 ss, 3 dd, 4 MM, 5 yyyy
frame_ok  out  1  one-cycle pulse: sentence complete, all fields well formed, checksum match
frame_err  out  1  one-cycle pulse: ZDA sentence aborted or malformed, or checksum mismatch
busy  out  1  high from an accepted '$' until the frame result or an abort

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters and checksum cleared.
- Latency: ascii_out and digit_valid are registered 1 cycle after the uart_valid of that byte. frame_ok or frame_err is asserted 1 cycle after the uart_valid of the second checksum char.
- Checksum: running XOR of every byte strictly between '$' and '*'.
- States:
  - IDLE: wait for '$' -> HDR.
  - HDR: 5 bytes are matched: talker[2] (per TALKER_CHECK), then 'Z','D','A'; then ',' -> F_TIME. A non-ZDA sentence returns silently to IDLE with no error pulse.
  - F_TIME: the first 6 chars must be digits, routed to hh, hh, mm, mm, ss, ss. Then either ',' or '.' followed by 0..FRAC_MAX digits (ignored) and ','. -> F_DAY.
  - F_DAY: exactly 2 digits (dd) then ','. -> F_MON.
  - F_MON: exactly 2 digits (MM) then ','. -> F_YEAR.
  - F_YEAR: exactly 4 digits (yyyy) then ','. -> F_SKIP.
  - F_SKIP: the two zone fields: digits, '-' and ',' are ignored; '*' -> CKS_HI.
  - CKS_HI, CKS_LO: each takes one hex char (0-9, A-F; lowercase is rejected). After CKS_LO, compare with the XOR and pulse frame_ok or frame_err. -> IDLE.
- Error (any state past HDR): wrong char class, wrong digit count, char count > MAX_LEN, or bad hex. Pulse frame_err once, then go to IDLE.
- A '$' in any non-IDLE state restarts the parse at HDR. If the restart happens after the ZDA header matched, frame_err is pulsed in the same cycle.
- A field with an empty or short digit count is an error. Because ascii2bin has no per-frame clear, downstream must reset it on frame_err; this is documented at the integration level.
- CR/LF after the checksum are ignored (IDLE). uart_valid while busy is never dropped.
- A char counter saturates at MAX_LEN+1 and does not wrap.

Decomposition:
- nmea_pkg holds:
  - char constants: '$', ',', '*', '.', '0', '9', 'A', 'F'
  - state enum: IDLE, HDR, F_TIME, F_DAY, F_MON, F_YEAR, F_SKIP, CKS_HI, CKS_LO
  - field index constants FLD_HH..FLD_YYYY and expected digit counts
- One sub-module, nmea_checksum: running XOR with clear/enable, hex-nibble decode, match output.

Test Plan:
1. Feed "$GPZDA,201530.00,04,07,2002,00,00*60\r\n" -> digit_valid pulses in order: 2 hh ('2','0'), 2 mm ('1','5'), 2 ss ('3','0'), 2 dd ('0','4'), 2 MM ('0','7'), 4 yyyy ('2','0','0','2'); single frame_ok 1 cycle after '0' of "60"; frame_err never set.
2. Same sentence with "*61" -> identical digit strobes, then frame_err pulse; frame_ok stays 0.
3. Feed "$GPGGA,123519,..." followed by a valid ZDA sentence -> no strobes and no pulses for GGA; the ZDA sentence yields frame_ok.
4. Feed "$GPZDA,2015,..." (short time field, ',' after 4 digits) -> frame_err 1 cycle after the ','; busy drops; later valid sentences still parse.
5. Assert rst_n low mid-year field, then release and feed a valid sentence -> outputs 0 during reset; frame_ok only for the post-reset sentence.
6. With TALKER_CHECK=0, feed "$GNZDA,..." -> frame_ok. With TALKER_CHECK=1, the same input gives silent ignore. Feed 90 chars without '*' -> frame_err when the 83rd char arrives.
